ff_pattern_checker: RTL and testbench

Self-checking stimulus/response block for the single-bit flip-flop conversions in this codebase (SR-to-D, D-to-SR, JK, T). It drives a pseudo-random D pattern into a flip-flop under test, issues that flip-flop's reset, samples its Q output and compares it against the expected registered value. It reports an error count, the first failing vector and a pass/done result. It sits beside each flip-flop instance on the hardware test harness and replaces bench-only stimulus.

---
 rtl/ff_pattern_checker.sv | 165 ++++++++++++++++
 tb/tb_ff_pattern_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ff_pattern_checker.sv
// Stimulus/response checker for a single-bit flip-flop under test: drives an LFSR
// D pattern, resets the flip-flop, and scores its Q against a 2-edge-delayed copy.
module ff_pattern_checker #(
    parameter int           LEN   = 16,
    parameter int           IDX_W = 4,
    parameter int           CNT_W = 8,
    parameter logic [7:0]   SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q_in,
    output logic             d_out,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_DUT = 3'd1,
        DRIVE   = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // An all-zero seed would lock the LFSR up, so it is replaced.
    localparam logic [7:0]   SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [IDX_W:0] LEN_CNT = (IDX_W + 1)'(LEN);

    state_t             state, state_nxt;
    logic [7:0]         lfsr, lfsr_nxt;
    logic [IDX_W:0]     vec_cnt, vec_cnt_nxt;
    logic [1:0]         exp_vld, exp_vld_nxt;
    logic [1:0]         exp_bit, exp_bit_nxt;
    logic [IDX_W-1:0]   exp_idx [2];
    logic [IDX_W-1:0]   exp_idx_nxt [2];

    logic               d_out_nxt, dut_rst_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0]   err_count_nxt, err_cmp;
    logic [IDX_W-1:0]   first_err_idx_nxt, first_cmp;
    logic               mismatch, push;

    // Scoring of the entry that is two edges old; runs in every state.
    always_comb begin
        mismatch  = exp_vld[1] && (q_in != exp_bit[1]);
        err_cmp   = err_count;
        first_cmp = first_err_idx;
        if (mismatch) begin
            if (err_count != {CNT_W{1'b1}})
                err_cmp = err_count + CNT_W'(1);
            if (first_err_idx == {IDX_W{1'b1}})
                first_cmp = exp_idx[1];
        end
    end

    // NOTE: every signal gets a default before the case statement, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt         = state;
        lfsr_nxt          = lfsr;
        vec_cnt_nxt       = vec_cnt;
        d_out_nxt         = 1'b0;
        dut_rst_nxt       = 1'b0;
        busy_nxt          = busy;
        done_nxt          = 1'b0;
        pass_nxt          = pass;
        err_count_nxt     = err_cmp;
        first_err_idx_nxt = first_cmp;
        push              = 1'b0;

        exp_vld_nxt    = {exp_vld[0], 1'b0};
        exp_bit_nxt    = {exp_bit[0], 1'b0};
        exp_idx_nxt[1] = exp_idx[0];
        exp_idx_nxt[0] = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt         = RST_DUT;
                    lfsr_nxt          = SEED_EFF;
                    vec_cnt_nxt       = '0;
                    err_count_nxt     = '0;
                    first_err_idx_nxt = {IDX_W{1'b1}};
                    pass_nxt          = 1'b0;
                    busy_nxt          = 1'b1;
                    dut_rst_nxt       = 1'b1;
                    exp_vld_nxt       = '0;
                end
            end
            RST_DUT: begin
                push      = 1'b1;
                state_nxt = DRIVE;
            end
            DRIVE: begin
                if (vec_cnt == LEN_CNT)
                    state_nxt = DRAIN;
                else
                    push = 1'b1;
            end
            DRAIN: begin
                // The last vector is scored on this edge, so pass includes it.
                state_nxt = DONE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                pass_nxt  = (err_cmp == '0);
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (push) begin
            d_out_nxt      = lfsr[0];
            lfsr_nxt       = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
            vec_cnt_nxt    = vec_cnt + (IDX_W + 1)'(1);
            exp_vld_nxt[0] = 1'b1;
            exp_bit_nxt[0] = lfsr[0];
            exp_idx_nxt[0] = vec_cnt[IDX_W-1:0];
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            vec_cnt       <= '0;
            exp_vld       <= '0;
            exp_bit       <= '0;
            exp_idx[0]    <= '0;
            exp_idx[1]    <= '0;
            d_out         <= 1'b0;
            dut_rst       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= {IDX_W{1'b1}};
        end else begin
            state         <= state_nxt;
            lfsr          <= lfsr_nxt;
            vec_cnt       <= vec_cnt_nxt;
            exp_vld       <= exp_vld_nxt;
            exp_bit       <= exp_bit_nxt;
            exp_idx[0]    <= exp_idx_nxt[0];
            exp_idx[1]    <= exp_idx_nxt[1];
            d_out         <= d_out_nxt;
            dut_rst       <= dut_rst_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
            err_count     <= err_count_nxt;
            first_err_idx <= first_err_idx_nxt;
        end
    end

endmodule

// File: tb/tb_ff_pattern_checker.sv
// Directed bench for ff_pattern_checker: ideal, stuck-at-0 and inverted flip-flop
// models, a narrow saturating counter instance, restart and mid-run reset.
module tb_ff_pattern_checker;

    // Hand-computed LFSR output from seed 8'hA5, bit i = vector i: 1010010101001110.
    localparam logic [15:0] EXP_SEQ  = 16'h72A5;
    localparam int          EXP_ONES = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    int         mode;   // 0 ideal, 1 stuck-at-0, 2 inverted

    logic       d_out, dut_rst, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] first_err_idx;
    logic       ff_q, q_in;

    logic       d_out3, dut_rst3, busy3, done3, pass3;
    logic [2:0] err_count3;
    logic [3:0] first_err_idx3;
    logic       ff_q3, q_in3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Flip-flop under test models: registered D with synchronous reset.
    always @(posedge clk) ff_q  <= dut_rst  ? 1'b0 : d_out;
    always @(posedge clk) ff_q3 <= dut_rst3 ? 1'b0 : d_out3;
    assign q_in  = (mode == 1) ? 1'b0 : (mode == 2) ? ~ff_q : ff_q;
    assign q_in3 = ~ff_q3;

    ff_pattern_checker #(.LEN(16), .IDX_W(4), .CNT_W(8), .SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .q_in(q_in),
        .d_out(d_out), .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    ff_pattern_checker #(.LEN(16), .IDX_W(4), .CNT_W(3), .SEED(8'hA5)) dut3 (
        .clk(clk), .reset(reset), .start(start), .q_in(q_in3),
        .d_out(d_out3), .dut_rst(dut_rst3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .first_err_idx(first_err_idx3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge where done is seen.
    task automatic run(input bit mid_start, output logic [15:0] seq, output int done_edge);
        seq       = '0;
        done_edge = -1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_e0", 32'(busy), 32'd1);
        check("dut_rst_after_e0", 32'(dut_rst), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check("dut_rst_after_e1", 32'(dut_rst), 32'd0);
            if (k <= 16) seq[k-1] = d_out;
            if (k == 17) check("d_out_after_drive", 32'(d_out), 32'd0);
            start = mid_start && (k >= 4) && (k <= 6);
            if (done) begin
                done_edge = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_out"},   32'(d_out),         32'd0);
        check({tag, "_dut_rst"}, 32'(dut_rst),       32'd0);
        check({tag, "_busy"},    32'(busy),          32'd0);
        check({tag, "_done"},    32'(done),          32'd0);
        check({tag, "_pass"},    32'(pass),          32'd0);
        check({tag, "_err"},     32'(err_count),     32'd0);
        check({tag, "_first"},   32'(first_err_idx), 32'hF);
        check({tag, "_err3"},    32'(err_count3),    32'd0);
        check({tag, "_state"},   32'(dut.state),     32'd0);
    endtask

    logic [15:0] seq;
    int          de;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        // Ideal flip-flop.
        run(1'b0, seq, de);
        check("ideal_seq",   32'(seq),           32'(EXP_SEQ));
        check("ideal_done",  32'(de),            32'd18);
        check("ideal_busy",  32'(busy),          32'd0);
        check("ideal_pass",  32'(pass),          32'd1);
        check("ideal_err",   32'(err_count),     32'd0);
        check("ideal_first", 32'(first_err_idx), 32'hF);
        check("sat_err3",    32'(err_count3),    32'd7);
        check("sat_pass3",   32'(pass3),         32'd0);
        check("sat_first3",  32'(first_err_idx3), 32'd0);

        // Start held on the DONE cycle is ignored; results held.
        start = 1'b1;
        @(negedge clk);
        check("done_cycle_start_ignored", 32'(busy), 32'd0);
        check("done_one_cycle",           32'(done), 32'd0);
        check("pass_held",                32'(pass), 32'd1);

        // Start on first IDLE cycle, with a start pulse mid-DRIVE.
        run(1'b1, seq, de);
        check("repeat_seq",  32'(seq),  32'(EXP_SEQ));
        check("repeat_done", 32'(de),   32'd18);
        check("repeat_pass", 32'(pass), 32'd1);

        // Q stuck at 0.
        @(negedge clk);
        mode = 1;
        run(1'b0, seq, de);
        check("stuck_done",  32'(de),            32'd18);
        check("stuck_err",   32'(err_count),     32'(EXP_ONES));
        check("stuck_first", 32'(first_err_idx), 32'd0);
        check("stuck_pass",  32'(pass),          32'd0);

        // Inverted Q.
        @(negedge clk);
        mode = 2;
        run(1'b0, seq, de);
        check("inv_err",   32'(err_count),     32'd16);
        check("inv_first", 32'(first_err_idx), 32'd0);
        check("inv_pass",  32'(pass),          32'd0);

        // Reset asserted while vector 8 is on d_out.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b1;
        @(negedge clk);
        run(1'b0, seq, de);
        check("after_abort_seq",   32'(seq),           32'(EXP_SEQ));
        check("after_abort_done",  32'(de),            32'd18);
        check("after_abort_pass",  32'(pass),          32'd1);
        check("after_abort_err",   32'(err_count),     32'd0);
        check("after_abort_first", 32'(first_err_idx), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
